// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: first-word-fall-through receive buffer behind the UART receiver.
// Each rising edge of RX_STATUS captures one RX_DATA byte. The CPU side sees the
// head byte combinationally on rd_data and pops it with rd_en.
//
// Handshake: the head entry is "valid" whenever empty is low, and rd_en is the
// "ready". A pop happens only in a cycle where both are high. rd_data must be
// consumed in that same cycle. rd_en while empty has no effect at all.
module uart_rx_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              sysclk,
  input  logic              reset,
  input  logic              RX_STATUS,
  input  logic [7:0]        RX_DATA,
  input  logic              rd_en,
  input  logic              clr_ovf,
  output logic [7:0]        rd_data,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   level,
  output logic              overflow,
  output logic              rx_irq
);

  localparam logic [ADDR_W:0] FULL_LEVEL = (ADDR_W+1)'(DEPTH);

  // Byte storage. It is deliberately not reset, because a flush only needs the pointers and level.
  logic [7:0]          mem [0:DEPTH-1];
  logic [ADDR_W-1:0]   wr_ptr;
  logic [ADDR_W-1:0]   rd_ptr;
  logic [ADDR_W:0]     level_q;
  logic                status_d;
  logic                overflow_q;

  logic                push;
  logic                pop;
  logic                accept;
  logic                drop;

  // Occupancy flags come only from the registered level.
  assign empty    = (level_q == '0);
  assign full     = (level_q == FULL_LEVEL);
  assign level    = level_q;
  assign overflow = overflow_q;
  assign rx_irq   = ~empty;

  // Strobe decode: one push per RX_STATUS rising edge, and a push into a full FIFO is
  // accepted only when a pop frees the slot in the same cycle.
  always_comb begin
    push   = RX_STATUS & ~status_d;
    pop    = rd_en & ~empty;
    accept = push & (~full | pop);
    drop   = push & ~accept;
  end

  // Fall-through head byte. It reads as zero when nothing is buffered.
  always_comb begin
    rd_data = 8'h00;
    if (!empty) begin
      rd_data = mem[rd_ptr];
    end
  end

  // Write port: store the byte sampled in the push cycle.
  always_ff @(posedge sysclk) begin
    if (accept) begin
      mem[wr_ptr] <= RX_DATA;
    end
  end

  // Pointer, level, edge-detect and sticky overflow state.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      status_d   <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      status_d <= RX_STATUS;
      if (accept) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + ADDR_W'(1);
      end
      level_q <= level_q + {{ADDR_W{1'b0}}, accept} - {{ADDR_W{1'b0}}, pop};
      // A dropped byte sets the flag even when clr_ovf arrives in the same cycle.
      if (drop) begin
        overflow_q <= 1'b1;
      end else if (clr_ovf) begin
        overflow_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed plus randomized stimulus for uart_rx_fifo, checked
// every cycle against a queue-based model, with a few literal expectations.
module tb_uart_rx_fifo;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic              sysclk;
  logic              reset;
  logic              RX_STATUS;
  logic [7:0]        RX_DATA;
  logic              rd_en;
  logic              clr_ovf;
  logic [7:0]        rd_data;
  logic              empty;
  logic              full;
  logic [ADDR_W:0]   level;
  logic              overflow;
  logic              rx_irq;

  int errors = 0;
  int checks = 0;
  bit model_on = 0;

  uart_rx_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .sysclk    (sysclk),
    .reset     (reset),
    .RX_STATUS (RX_STATUS),
    .RX_DATA   (RX_DATA),
    .rd_en     (rd_en),
    .clr_ovf   (clr_ovf),
    .rd_data   (rd_data),
    .empty     (empty),
    .full      (full),
    .level     (level),
    .overflow  (overflow),
    .rx_irq    (rx_irq)
  );

  // ---------------- clock ----------------
  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  // ---------------- reference model ----------------
  logic [7:0] exp_q[$];
  bit         m_ovf;
  bit         m_prev;

  always @(posedge sysclk) begin
    bit is_push;
    bit is_pop;
    bit dropped;
    if (reset) begin
      exp_q.delete();
      m_ovf  = 0;
      m_prev = 0;
    end else begin
      is_push = RX_STATUS && !m_prev;
      is_pop  = rd_en && (exp_q.size() > 0);
      dropped = 0;
      if (is_pop) void'(exp_q.pop_front());
      if (is_push) begin
        if (exp_q.size() < DEPTH) exp_q.push_back(RX_DATA);
        else dropped = 1;
      end
      if (dropped) m_ovf = 1;
      else if (clr_ovf) m_ovf = 0;
      m_prev = RX_STATUS;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard compare, every cycle ----------------
  always @(negedge sysclk) begin
    int sz;
    if (model_on) begin
      sz = exp_q.size();
      check("cmp_rd_data",  int'(rd_data),  (sz > 0) ? int'(exp_q[0]) : 0);
      check("cmp_level",    int'(level),    sz);
      check("cmp_empty",    int'(empty),    (sz == 0) ? 1 : 0);
      check("cmp_full",     int'(full),     (sz == DEPTH) ? 1 : 0);
      check("cmp_irq",      int'(rx_irq),   (sz != 0) ? 1 : 0);
      check("cmp_overflow", int'(overflow), int'(m_ovf));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycle(input int n);
    repeat (n) begin
      @(posedge sysclk);
      #1;
    end
  endtask

  task automatic push_byte(input logic [7:0] b, input int hold);
    RX_STATUS = 1'b1;
    RX_DATA   = b;
    cycle(hold);
    RX_STATUS = 1'b0;
    cycle(1);
  endtask

  task automatic pop_one();
    rd_en = 1'b1;
    cycle(1);
    rd_en = 1'b0;
  endtask

  task automatic fill_seq(input logic [7:0] first);
    logic [7:0] b;
    b = first;
    for (int i = 0; i < DEPTH; i++) begin
      push_byte(b, 1);
      b = b + 8'd1;
    end
  endtask

  task automatic random_phase(input int n, input int rd_pct);
    for (int i = 0; i < n; i++) begin
      RX_STATUS = ($urandom_range(0, 99) < 50);
      RX_DATA   = 8'($urandom);
      rd_en     = ($urandom_range(0, 99) < rd_pct);
      clr_ovf   = ($urandom_range(0, 99) < 5);
      cycle(1);
    end
    RX_STATUS = 1'b0;
    rd_en     = 1'b0;
    clr_ovf   = 1'b0;
    cycle(1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset     = 1'b1;
    RX_STATUS = 1'b0;
    RX_DATA   = 8'h00;
    rd_en     = 1'b0;
    clr_ovf   = 1'b0;
    cycle(3);
    reset    = 1'b0;
    model_on = 1;
    cycle(1);

    // Reset state
    check("rst_rd_data", int'(rd_data), 0);
    check("rst_empty",   int'(empty), 1);
    check("rst_level",   int'(level), 0);
    check("rst_irq",     int'(rx_irq), 0);

    // Long RX_STATUS pulse yields exactly one byte
    push_byte(8'hA5, 10);
    check("a5_level",   int'(level), 1);
    check("a5_rd_data", int'(rd_data), 'hA5);
    check("a5_irq",     int'(rx_irq), 1);
    pop_one();
    check("a5_empty",   int'(empty), 1);
    check("a5_zero",    int'(rd_data), 0);

    // Fill to full, drain in order
    fill_seq(8'h01);
    check("fill_full",  int'(full), 1);
    check("fill_level", int'(level), 16);
    for (int i = 0; i < DEPTH; i++) begin
      check("drain_order", int'(rd_data), i + 1);
      pop_one();
    end
    check("drain_empty", int'(empty), 1);

    // Overflow, set-wins-over-clear, then clear alone
    fill_seq(8'h01);
    push_byte(8'hFF, 1);
    check("ovf_set",   int'(overflow), 1);
    check("ovf_level", int'(level), 16);
    RX_STATUS = 1'b1; RX_DATA = 8'hEE; clr_ovf = 1'b1;
    cycle(1);
    RX_STATUS = 1'b0; clr_ovf = 1'b0;
    cycle(1);
    check("ovf_set_wins", int'(overflow), 1);
    clr_ovf = 1'b1;
    cycle(1);
    clr_ovf = 1'b0;
    check("ovf_cleared", int'(overflow), 0);

    // Push and pop together while full
    RX_STATUS = 1'b1; RX_DATA = 8'h5A; rd_en = 1'b1;
    cycle(1);
    RX_STATUS = 1'b0; rd_en = 1'b0;
    cycle(1);
    check("fullpp_level", int'(level), 16);
    check("fullpp_ovf",   int'(overflow), 0);
    for (int i = 0; i < DEPTH; i++) begin
      check("fullpp_order", int'(rd_data), (i < DEPTH - 1) ? i + 2 : 'h5A);
      pop_one();
    end

    // Push and pop together while empty
    RX_STATUS = 1'b1; RX_DATA = 8'h3C; rd_en = 1'b1;
    cycle(1);
    RX_STATUS = 1'b0; rd_en = 1'b0;
    check("emptypp_level", int'(level), 1);
    check("emptypp_data",  int'(rd_data), 'h3C);
    cycle(1);
    pop_one();

    // Wrap-around: 40 push/pop pairs at level 3
    for (int i = 0; i < 3; i++) push_byte(8'($urandom), 1);
    for (int i = 0; i < 40; i++) begin
      RX_STATUS = 1'b1; RX_DATA = 8'($urandom); rd_en = 1'b1;
      cycle(1);
      RX_STATUS = 1'b0; rd_en = 1'b0;
      cycle(1);
    end
    check("wrap_level", int'(level), 3);
    for (int i = 0; i < 3; i++) pop_one();

    // Randomized traffic: fill-heavy then drain-heavy
    random_phase(400, 20);
    random_phase(400, 70);
    random_phase(300, 45);

    // Reset with five bytes buffered and overflow set
    while (!empty) pop_one();
    fill_seq(8'h40);
    push_byte(8'h99, 1);
    for (int i = 0; i < DEPTH - 5; i++) pop_one();
    check("prerst_level", int'(level), 5);
    reset = 1'b1;
    cycle(1);
    reset = 1'b0;
    check("postrst_level", int'(level), 0);
    check("postrst_empty", int'(empty), 1);
    check("postrst_ovf",   int'(overflow), 0);
    rd_en = 1'b1;
    cycle(2);
    rd_en = 1'b0;
    check("postrst_rd_level", int'(level), 0);
    check("postrst_rd_data",  int'(rd_data), 0);
    cycle(2);

    model_on = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
